// File: rtl/mdt_update_controller_pkg.sv
// Shared MDT types for the update controller: index path, entry layout, FSM states.
package mdt_update_controller_pkg;

    localparam int STORE_ISSUE_WIDTH       = 2;
    localparam int MDT_ENTRY_NUM           = 16;
    localparam int MDT_ENTRY_NUM_BIT_WIDTH = $clog2(MDT_ENTRY_NUM);

    typedef logic [MDT_ENTRY_NUM_BIT_WIDTH-1:0] MDT_IndexPath;

    typedef struct packed {
        logic counter;
    } MDT_Entry;

    typedef enum logic [1:0] {
        MDT_UPD_INIT,
        MDT_UPD_RUN,
        MDT_UPD_CLEAR
    } MDT_UpdateState;

    function automatic MDT_Entry mdtEntry(input logic learn);
        MDT_Entry e;
        e.counter = learn;
        return e;
    endfunction

endpackage

// File: rtl/mdt_update_controller_if.sv
// Violation-report inputs and MDT write-port outputs of the update controller.
interface mdt_update_controller_if
    import mdt_update_controller_pkg::*;
#(
    parameter int STORE_PORTS = STORE_ISSUE_WIDTH,
    parameter int IDX_W       = MDT_ENTRY_NUM_BIT_WIDTH
);
    logic [STORE_PORTS-1:0]            violation;
    logic [STORE_PORTS-1:0][IDX_W-1:0] violIndex;
    logic                              mdtWE;
    logic [IDX_W-1:0]                  mdtWA;
    MDT_Entry                          mdtWV;
    logic                              initBusy;
    logic                              queueFull;
    logic [15:0]                       dropCount;

    modport master (
        output violation, violIndex,
        input  mdtWE, mdtWA, mdtWV, initBusy, queueFull, dropCount
    );

    modport slave (
        input  violation, violIndex,
        output mdtWE, mdtWA, mdtWV, initBusy, queueFull, dropCount
    );
endinterface

// File: rtl/mdt_update_queue.sv
// Multi-push, single-pop circular FIFO of MDT learn indices with same-cycle dedup
// and a per-cycle count of requests refused for lack of space.
module mdt_update_queue
    import mdt_update_controller_pkg::*;
#(
    parameter int STORE_PORTS = STORE_ISSUE_WIDTH,
    parameter int IDX_W       = MDT_ENTRY_NUM_BIT_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [STORE_PORTS-1:0]                pushValid,
    input  logic [STORE_PORTS-1:0][IDX_W-1:0]     pushIndex,
    input  logic                                  pop,
    output logic                                  empty,
    output logic [IDX_W-1:0]                      headIndex,
    output logic                                  full,
    output logic [$clog2(STORE_PORTS+1)-1:0]      dropNum
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DW    = $clog2(STORE_PORTS+1);

    typedef logic [CNT_W-1:0] cnt_t;

    logic [DEPTH-1:0][IDX_W-1:0]       mem;
    logic [PTR_W-1:0]                  wrPtr, rdPtr;
    cnt_t                              count, cap, accCnt, countNext;
    logic [STORE_PORTS-1:0]            accept;
    logic [STORE_PORTS-1:0][PTR_W-1:0] slot;
    logic                              popEff, dup;

    assign empty     = (count == '0);
    assign popEff    = pop && !empty;
    assign headIndex = mem[rdPtr];

    // A pop in the same cycle frees one extra slot for the incoming requests.
    always_comb begin
        cap     = cnt_t'(DEPTH) - count + cnt_t'(popEff);
        accCnt  = '0;
        dropNum = '0;
        accept  = '0;
        slot    = '0;
        dup     = 1'b0;
        for (int p = 0; p < STORE_PORTS; p++) begin
            dup = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (accept[q] && pushIndex[q] == pushIndex[p]) dup = 1'b1;
            end
            if (pushValid[p] && !dup) begin
                if (accCnt < cap) begin
                    accept[p] = 1'b1;
                    slot[p]   = wrPtr + accCnt[PTR_W-1:0];
                    accCnt    = accCnt + cnt_t'(1);
                end else begin
                    dropNum = dropNum + DW'(1);
                end
            end
        end
        countNext = count - cnt_t'(popEff) + accCnt;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < STORE_PORTS; p++) begin
            if (accept[p]) mem[slot[p]] <= pushIndex[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            wrPtr <= wrPtr + accCnt[PTR_W-1:0];
            if (popEff) rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
            full  <= (countNext == cnt_t'(DEPTH));
        end
    end

endmodule

// File: rtl/mdt_update_controller.sv
// Owns the MDT write port: init sweep after reset, optional periodic clear sweeps,
// and one-per-cycle drain of queued violation learns.
module mdt_update_controller
    import mdt_update_controller_pkg::*;
#(
    parameter int STORE_PORTS    = STORE_ISSUE_WIDTH,
    parameter int ENTRY_NUM      = MDT_ENTRY_NUM,
    parameter int QUEUE_DEPTH    = 4,
    parameter int CLEAR_INTERVAL = 0
) (
    input logic                     clk,
    input logic                     rst,
    mdt_update_controller_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int IVL_W = (CLEAR_INTERVAL > 1) ? $clog2(CLEAR_INTERVAL) : 1;
    localparam int DW    = $clog2(STORE_PORTS+1);

    MDT_UpdateState   state, stateNext;
    logic [IDX_W-1:0] sweepIdx, sweepNext;
    logic [IVL_W-1:0] intervalCnt, intervalNext;
    logic             clearDue;

    logic             weReg, weNext;
    logic [IDX_W-1:0] waReg, waNext;
    MDT_Entry         wvReg, wvNext;
    logic             busyReg;
    logic [15:0]      dropReg;
    logic [16:0]      dropSum;

    logic             qEmpty, qPop, qFull;
    logic [IDX_W-1:0] qHead;
    logic [DW-1:0]    qDrop;

    mdt_update_queue #(
        .STORE_PORTS (STORE_PORTS),
        .IDX_W       (IDX_W),
        .DEPTH       (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .pushValid (bus.violation),
        .pushIndex (bus.violIndex),
        .pop       (qPop),
        .empty     (qEmpty),
        .headIndex (qHead),
        .full      (qFull),
        .dropNum   (qDrop)
    );

    assign clearDue = (CLEAR_INTERVAL != 0) &&
                      (intervalCnt == IVL_W'(CLEAR_INTERVAL - 1));

    always_comb begin
        stateNext    = state;
        sweepNext    = sweepIdx;
        intervalNext = intervalCnt;
        weNext       = 1'b0;
        waNext       = waReg;
        wvNext       = wvReg;
        qPop         = 1'b0;
        unique case (state)
            MDT_UPD_INIT, MDT_UPD_CLEAR: begin
                weNext    = 1'b1;
                waNext    = sweepIdx;
                wvNext    = mdtEntry(1'b0);
                sweepNext = sweepIdx + IDX_W'(1);
                if (sweepIdx == IDX_W'(ENTRY_NUM - 1)) stateNext = MDT_UPD_RUN;
            end
            MDT_UPD_RUN: begin
                if (!qEmpty) begin
                    qPop   = 1'b1;
                    weNext = 1'b1;
                    waNext = qHead;
                    wvNext = mdtEntry(1'b1);
                end
                intervalNext = intervalCnt + IVL_W'(1);
                // Queued learns are not snooped; they land after the sweep.
                if (clearDue) begin
                    stateNext    = MDT_UPD_CLEAR;
                    sweepNext    = '0;
                    intervalNext = '0;
                end
            end
            default: stateNext = MDT_UPD_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MDT_UPD_INIT;
            sweepIdx    <= '0;
            intervalCnt <= '0;
        end else begin
            state       <= stateNext;
            sweepIdx    <= sweepNext;
            intervalCnt <= intervalNext;
        end
    end

    assign dropSum = {1'b0, dropReg} + 17'(qDrop);

    // initBusy lags the state by one cycle so it covers the last init write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weReg   <= 1'b0;
            waReg   <= '0;
            wvReg   <= '0;
            busyReg <= 1'b1;
            dropReg <= '0;
        end else begin
            weReg   <= weNext;
            waReg   <= waNext;
            wvReg   <= wvNext;
            busyReg <= (state == MDT_UPD_INIT);
            dropReg <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
        end
    end

    assign bus.mdtWE     = weReg;
    assign bus.mdtWA     = waReg;
    assign bus.mdtWV     = wvReg;
    assign bus.initBusy  = busyReg;
    assign bus.queueFull = qFull;
    assign bus.dropCount = dropReg;

endmodule

// File: tb/tb_mdt_update_controller.sv
// Bench for mdt_update_controller: time-based phase model plus FIFO queue model,
// directed literal checks, then randomized violation traffic.
module tb_mdt_update_controller;
    import mdt_update_controller_pkg::*;

    localparam int SP = 2;
    localparam int EN = 16;
    localparam int IW = 4;
    localparam int QD = 4;
    localparam int CI = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdt_update_controller_if #(.STORE_PORTS(SP), .IDX_W(IW)) bus ();

    mdt_update_controller #(
        .STORE_PORTS    (SP),
        .ENTRY_NUM      (EN),
        .QUEUE_DEPTH    (QD),
        .CLEAR_INTERVAL (CI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset release, learn queue, drop total, expected outputs.
    int   edgeCnt = 0;
    int   mq[$];
    int   mDrop   = 0;
    logic expWE   = 1'b0;
    int   expWA   = 0;
    int   expWV   = 0;
    logic expBusy = 1'b1;
    logic expFull = 1'b0;
    int   expDrop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [SP-1:0] v, input int a, input int b);
        bus.violation    = v;
        bus.violIndex[0] = IW'(a);
        bus.violIndex[1] = IW'(b);
    endtask

    // Phase is a pure function of time since reset: INIT for EN cycles, then
    // CI cycles of RUN followed by EN cycles of CLEAR, repeating.
    always @(posedge clk) begin
        int c, r, ph, sidx, cap, ix;
        bit pop, dup;
        int acc[$];
        if (rst) begin
            mq.delete();
            mDrop   = 0;
            edgeCnt = 0;
            expWE   = 1'b0;
            expWA   = 0;
            expWV   = 0;
            expBusy = 1'b1;
            expFull = 1'b0;
            expDrop = 0;
        end else begin
            c = edgeCnt;
            edgeCnt++;
            sidx = 0;
            if (c < EN) begin
                ph = 0; sidx = c;
            end else if (CI == 0) begin
                ph = 1;
            end else begin
                r = (c - EN) % (CI + EN);
                if (r < CI) ph = 1;
                else begin ph = 2; sidx = r - CI; end
            end
            pop = (ph == 1) && (mq.size() > 0);
            if (ph != 1) begin
                expWE = 1'b1; expWA = sidx; expWV = 0;
            end else if (pop) begin
                expWE = 1'b1; expWA = mq[0]; expWV = 1;
            end else begin
                expWE = 1'b0;
            end
            expBusy = (ph == 0);
            cap = QD - mq.size() + (pop ? 1 : 0);
            acc.delete();
            for (int p = 0; p < SP; p++) begin
                if (bus.violation[p]) begin
                    ix  = int'(bus.violIndex[p]);
                    dup = 1'b0;
                    foreach (acc[k]) if (acc[k] == ix) dup = 1'b1;
                    if (!dup) begin
                        if (acc.size() < cap) acc.push_back(ix);
                        else if (mDrop < 65535) mDrop++;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            foreach (acc[k]) mq.push_back(acc[k]);
            expFull = (mq.size() == QD);
            expDrop = mDrop;
        end
    end

    always @(negedge clk) begin
        chk("mdtWE", bus.mdtWE, expWE);
        if (expWE) begin
            chk("mdtWA", bus.mdtWA, expWA);
            chk("mdtWV", bus.mdtWV, expWV);
        end
        chk("initBusy", bus.initBusy, expBusy);
        chk("queueFull", bus.queueFull, expFull);
        chk("dropCount", bus.dropCount, expDrop);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SP-1:0] v;
        int a, b;
        drive('0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rstWE", bus.mdtWE, 0);
        chk("rstWA", bus.mdtWA, 0);
        chk("rstWV", bus.mdtWV, 0);
        chk("rstBusy", bus.initBusy, 1);
        chk("rstFull", bus.queueFull, 0);
        chk("rstDrop", bus.dropCount, 0);
        rst = 1'b0;

        // Init sweep: index k written in cycle k+1, initBusy low from cycle EN+1.
        for (int k = 0; k < EN; k++) begin
            @(negedge clk);
            chk("initWE", bus.mdtWE, 1);
            chk("initWA", bus.mdtWA, k);
            chk("initWV", bus.mdtWV, 0);
            chk("initBusyHi", bus.initBusy, 1);
        end
        @(negedge clk);
        chk("initBusyLo", bus.initBusy, 0);
        chk("idleWE", bus.mdtWE, 0);

        // Single learn: request in cycle 17, write in cycle 19.
        drive(2'b01, 5, 0);
        @(negedge clk); drive('0, 0, 0);
        chk("learnGap", bus.mdtWE, 0);
        @(negedge clk);
        chk("learnWE", bus.mdtWE, 1);
        chk("learnWA", bus.mdtWA, 5);
        chk("learnWV", bus.mdtWV, 1);
        @(negedge clk);
        chk("learnDone", bus.mdtWE, 0);

        // Two distinct ports, drained in port order.
        drive(2'b11, 3, 9);
        @(negedge clk); drive('0, 0, 0);
        @(negedge clk);
        chk("dualWA0", bus.mdtWA, 3);
        @(negedge clk);
        chk("dualWA1", bus.mdtWA, 9);
        @(negedge clk);
        chk("dualDone", bus.mdtWE, 0);
        chk("dualDrop", bus.dropCount, 0);

        // Same index on both ports: one write, silent drop.
        drive(2'b11, 7, 7);
        @(negedge clk); drive('0, 0, 0);
        @(negedge clk);
        chk("dedupWE", bus.mdtWE, 1);
        chk("dedupWA", bus.mdtWA, 7);
        @(negedge clk);
        chk("dedupOnce", bus.mdtWE, 0);
        chk("dedupDrop", bus.dropCount, 0);

        // Fill across the end of the first clear sweep (decision cycles 48..63).
        while (edgeCnt < 62) @(negedge clk);
        drive(2'b11, 1, 2);
        @(negedge clk); drive(2'b11, 3, 4);
        @(negedge clk); drive(2'b11, 5, 6);
        chk("clrLastWA", bus.mdtWA, 15);
        chk("clrLastWV", bus.mdtWV, 0);
        @(negedge clk); drive('0, 0, 0);
        chk("fullFlag", bus.queueFull, 1);
        chk("fullDrop", bus.dropCount, 1);
        chk("fullWA", bus.mdtWA, 1);
        for (int j = 2; j <= 5; j++) begin
            @(negedge clk);
            chk("fullDrainWE", bus.mdtWE, 1);
            chk("fullDrainWA", bus.mdtWA, j);
            chk("fullDrainWV", bus.mdtWV, 1);
        end
        @(negedge clk);
        chk("fullDrainEnd", bus.mdtWE, 0);

        // Learn queued at clear entry lands after the second sweep.
        while (edgeCnt < 95) @(negedge clk);
        drive(2'b01, 4, 0);
        @(negedge clk); drive('0, 0, 0);
        chk("preClrWE", bus.mdtWE, 0);
        @(negedge clk);
        chk("clrFirstWA", bus.mdtWA, 0);
        chk("clrFirstWV", bus.mdtWV, 0);
        while (edgeCnt < 112) @(negedge clk);
        chk("clrEndWA", bus.mdtWA, 15);
        @(negedge clk);
        chk("postClrWE", bus.mdtWE, 1);
        chk("postClrWA", bus.mdtWA, 4);
        chk("postClrWV", bus.mdtWV, 1);
        chk("postClrBusy", bus.initBusy, 0);

        // Reset in the middle of the third sweep with learns still queued.
        while (edgeCnt < 148) @(negedge clk);
        drive(2'b11, 10, 11);
        @(negedge clk); drive('0, 0, 0);
        @(negedge clk);
        chk("sweepWE", bus.mdtWE, 1);
        #1 rst = 1'b1;
        #1;
        chk("abortWE", bus.mdtWE, 0);
        chk("abortWA", bus.mdtWA, 0);
        chk("abortBusy", bus.initBusy, 1);
        chk("abortDrop", bus.dropCount, 0);
        chk("abortFull", bus.queueFull, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Randomized traffic, with one reset pulse part way through.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int p = 0; p < SP; p++) v[p] = ($urandom_range(0, 99) < 45);
            a = $urandom_range(0, EN - 1);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, EN - 1);
            drive(v, a, b);
            if (n == 1500) begin
                #1 rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk); drive('0, 0, 0);
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
